iram_controller: RTL and testbench

- Responder side of the instruction-fetch miss interface: serves fetch-unit cache-miss requests (miss_cache, ram_address) by reading a full cache line from the instruction RAM backend.
- Returns the line one word per beat on mem_word, qualified by word_ready.
- Sits between the core's fetch unit and a synchronous-read, fixed-latency instruction RAM.
- Pipelined issue: one backend read per cycle, with an in-flight valid shift register tracking returns.

---
 rtl/iram_controller_if.sv | 34 +++
 rtl/iram_controller.sv | 121 ++++++++++++
 tb/tb_iram_controller.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/iram_controller_if.sv
// Instruction-fetch miss interface between the fetch unit, the miss
// controller and the synchronous-read instruction RAM backend.
// The master modport is the environment (fetch unit plus RAM).
// The slave modport is the controller that answers the miss.
interface iram_controller_if #(
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4
);
  localparam int OFF_W = $clog2(LINE_WORDS);

  logic                 miss_cache;
  logic [PC_SIZE-1:0]   ram_address;
  logic [WORD_SIZE-1:0] mem_word;
  logic                 word_ready;
  logic [OFF_W-1:0]     word_idx;
  logic                 line_done;
  logic                 busy;
  logic                 ram_rd_en;
  logic [PC_SIZE-3:0]   ram_rd_addr;
  logic [WORD_SIZE-1:0] ram_rd_data;

  modport master (
    output miss_cache, ram_address, ram_rd_data,
    input  mem_word, word_ready, word_idx, line_done, busy,
    input  ram_rd_en, ram_rd_addr
  );

  modport slave (
    input  miss_cache, ram_address, ram_rd_data,
    output mem_word, word_ready, word_idx, line_done, busy,
    output ram_rd_en, ram_rd_addr
  );
endinterface

// File: rtl/iram_controller.sv
// Instruction RAM miss controller. It accepts a fetch miss and issues one
// backend read per cycle for the whole cache line. It then returns the
// words back-to-back, one per word_ready pulse.
// Optional macro IRAM_CRITICAL_WORD_FIRST_EN: when defined, the line is
// fetched starting at the missing word and wraps within the line.
module iram_controller #(
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4,
  parameter int RD_LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  iram_controller_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int WA_W  = PC_SIZE - 2;
  localparam int TAG_W = WA_W - OFF_W;
  localparam int CNT_W = OFF_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [TAG_W-1:0]     line_tag;
  logic [OFF_W-1:0]     req_off;
  logic [OFF_W-1:0]     issue_cnt;
  logic [OFF_W-1:0]     issue_off;
  logic [CNT_W-1:0]     ret_cnt;
  logic                 rd_en;
  logic                 accept;
  logic                 ret_all;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [OFF_W-1:0]     off_pipe [RD_LATENCY];
  logic [WORD_SIZE-1:0] mem_word_q;
  logic [OFF_W-1:0]     word_idx_q;
  logic                 word_ready_q;
  logic                 line_done_q;

  assign accept  = (state == IDLE) && bus.miss_cache;
  assign ret_all = (ret_cnt == CNT_W'(LINE_WORDS));

`ifdef IRAM_CRITICAL_WORD_FIRST_EN
  assign issue_off = issue_cnt + req_off;
`else
  assign issue_off = issue_cnt;
`endif

  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_rd_addr = rd_en ? {line_tag, issue_off} : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.mem_word    = mem_word_q;
  assign bus.word_idx    = word_idx_q;
  assign bus.word_ready  = word_ready_q;
  assign bus.line_done   = line_done_q;

  // Next-state decode; a miss still held in DONE is stale and only waits for release
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:  if (bus.miss_cache) state_nxt = ISSUE;
      ISSUE: begin
        rd_en = 1'b1;
        if (issue_cnt == OFF_W'(LINE_WORDS - 1))
          state_nxt = ret_all ? DONE : DRAIN;
      end
      DRAIN: if (ret_all) state_nxt = DONE;
      DONE:  if (!bus.miss_cache) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request latch and issue counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_tag  <= '0;
      req_off   <= '0;
      issue_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        line_tag  <= bus.ram_address[PC_SIZE-1:2+OFF_W];
        req_off   <= bus.ram_address[2+OFF_W-1:2];
        issue_cnt <= '0;
      end else if (rd_en) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

  // In-flight tracking and return register; clearing the pipe on reset drops late data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      for (int i = 0; i < RD_LATENCY; i++) off_pipe[i] <= '0;
      mem_word_q   <= '0;
      word_idx_q   <= '0;
      word_ready_q <= 1'b0;
      line_done_q  <= 1'b0;
      ret_cnt      <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      off_pipe[0] <= issue_off;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        off_pipe[i] <= off_pipe[i-1];
      end
      word_ready_q <= vld_pipe[RD_LATENCY-1];
      line_done_q  <= vld_pipe[RD_LATENCY-1] &&
                      (ret_cnt == CNT_W'(LINE_WORDS - 1));
      if (vld_pipe[RD_LATENCY-1]) begin
        mem_word_q <= bus.ram_rd_data;
        word_idx_q <= off_pipe[RD_LATENCY-1];
        ret_cnt    <= ret_cnt + 1'b1;
      end else if (state == IDLE) begin
        ret_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_iram_controller.sv
// Testbench for iram_controller. It runs table-driven per-cycle vectors for
// aligned and unaligned misses. It then runs hand sequences for a held
// stale miss, a reset in the middle of a burst, and a back-to-back line.
// The backend model returns word address * 3 after LAT cycles.
module tb_iram_controller;
  localparam int LAT = 2;
  localparam int LW  = 4;

  typedef struct {
    logic        rst;
    logic        miss;
    logic [31:0] addr;
    logic        en;
    logic [29:0] rd_addr;
    logic        wr;
    logic [31:0] word;
    logic [1:0]  idx;
    logic        ld;
    logic        busy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [20];
  logic [31:0] rd_pipe [LAT];

  iram_controller_if #(.PC_SIZE(32), .WORD_SIZE(32), .LINE_WORDS(LW)) bus ();

  iram_controller #(
    .PC_SIZE(32), .WORD_SIZE(32), .LINE_WORDS(LW), .RD_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed-latency RAM model: returns junk when no read was issued
  always @(posedge clk) begin
    rd_pipe[0] <= bus.ram_rd_en ? 32'({2'b00, bus.ram_rd_addr} * 3) : 32'hDEAD_BEEF;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.ram_rd_data = rd_pipe[LAT-1];

  // Absolute time bound so the run cannot hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic m, input logic [31:0] a,
                              input logic e, input logic [29:0] ra, input logic w,
                              input logic [31:0] wd, input logic [1:0] ix,
                              input logic l, input logic b);
    vec_t v;
    v.rst = r; v.miss = m; v.addr = a; v.en = e; v.rd_addr = ra;
    v.wr = w; v.word = wd; v.idx = ix; v.ld = l; v.busy = b;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst             = v.rst;
    bus.miss_cache  = v.miss;
    bus.ram_address = v.addr;
  endtask

  // Generic burst: drives a miss from IDLE, optionally holds it for hold cycles in DONE
  task automatic checkBurst(input logic [31:0] addr, input int hold);
    int wi, lb, o, off;
    wi = int'(addr[31:2]);
    lb = wi & ~(LW - 1);
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
    o = wi % LW;
`else
    o = 0;
`endif
    @(negedge clk);
    bus.miss_cache  = 1'b1;
    bus.ram_address = addr;
    #1;
    checkOutput("burst_idle_busy", 32'(bus.busy), 32'd0);
    for (int c = 1; c <= LW + LAT + 3 + hold; c++) begin
      @(negedge clk);
      bus.miss_cache  = (hold > 0) && (c <= LW + LAT + 1 + hold);
      bus.ram_address = 32'hFFFF_FFF0;
      #1;
      checkOutput("burst_rd_en", 32'(bus.ram_rd_en), 32'(c <= LW));
      if (c <= LW) begin
        off = (o + c - 1) % LW;
        checkOutput("burst_rd_addr", 32'(bus.ram_rd_addr), 32'(lb + off));
      end
      checkOutput("burst_word_ready", 32'(bus.word_ready),
                  32'((c >= LAT + 2) && (c <= LAT + 1 + LW)));
      if ((c >= LAT + 2) && (c <= LAT + 1 + LW)) begin
        off = (o + c - LAT - 2) % LW;
        checkOutput("burst_mem_word", bus.mem_word, 32'((lb + off) * 3));
        checkOutput("burst_word_idx", 32'(bus.word_idx), 32'(off));
      end
      checkOutput("burst_line_done", 32'(bus.line_done), 32'(c == LAT + 1 + LW));
      checkOutput("burst_busy", 32'(bus.busy), 32'(c <= LW + LAT + 2 + hold));
    end
  endtask

  initial begin
    logic [29:0] ua [4];
    logic [31:0] uw [4];
    logic [1:0]  ui [4];
    checks = 0;
    errors = 0;

`ifdef IRAM_CRITICAL_WORD_FIRST_EN
    ua = '{30'h43, 30'h40, 30'h41, 30'h42};
    uw = '{32'hC9, 32'hC0, 32'hC3, 32'hC6};
    ui = '{2'd3, 2'd0, 2'd1, 2'd2};
`else
    ua = '{30'h40, 30'h41, 30'h42, 30'h43};
    uw = '{32'hC0, 32'hC3, 32'hC6, 32'hC9};
    ui = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif

    // Aligned miss at 0x100 right out of reset with miss held through reset
    vecs[0]  = mk(0, 1, 32'h100,       0, 30'h00, 0, 32'h00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 32'hFFFF_FFFC, 1, 30'h40, 0, 32'h00, 0, 0, 1);
    vecs[2]  = mk(0, 0, 32'hFFFF_FFFC, 1, 30'h41, 0, 32'h00, 0, 0, 1);
    vecs[3]  = mk(0, 0, 32'hFFFF_FFFC, 1, 30'h42, 0, 32'h00, 0, 0, 1);
    vecs[4]  = mk(0, 0, 32'hFFFF_FFFC, 1, 30'h43, 1, 32'hC0, 0, 0, 1);
    vecs[5]  = mk(0, 0, 32'h0,         0, 30'h00, 1, 32'hC3, 1, 0, 1);
    vecs[6]  = mk(0, 0, 32'h0,         0, 30'h00, 1, 32'hC6, 2, 0, 1);
    vecs[7]  = mk(0, 0, 32'h0,         0, 30'h00, 1, 32'hC9, 3, 1, 1);
    vecs[8]  = mk(0, 0, 32'h0,         0, 30'h00, 0, 32'hC9, 0, 0, 1);
    vecs[9]  = mk(0, 0, 32'h0,         0, 30'h00, 0, 32'hC9, 0, 0, 0);
    // Unaligned miss at 0x10C
    vecs[10] = mk(0, 1, 32'h10C,       0, 30'h00,  0, 32'hC9, 0,     0, 0);
    vecs[11] = mk(0, 0, 32'h0,         1, ua[0],   0, 32'hC9, 0,     0, 1);
    vecs[12] = mk(0, 0, 32'h0,         1, ua[1],   0, 32'hC9, 0,     0, 1);
    vecs[13] = mk(0, 0, 32'h0,         1, ua[2],   0, 32'hC9, 0,     0, 1);
    vecs[14] = mk(0, 0, 32'h0,         1, ua[3],   1, uw[0],  ui[0], 0, 1);
    vecs[15] = mk(0, 0, 32'h0,         0, 30'h00,  1, uw[1],  ui[1], 0, 1);
    vecs[16] = mk(0, 0, 32'h0,         0, 30'h00,  1, uw[2],  ui[2], 0, 1);
    vecs[17] = mk(0, 0, 32'h0,         0, 30'h00,  1, uw[3],  ui[3], 1, 1);
    vecs[18] = mk(0, 0, 32'h0,         0, 30'h00,  0, uw[3],  0,     0, 1);
    vecs[19] = mk(0, 0, 32'h0,         0, 30'h00,  0, uw[3],  0,     0, 0);

    // Reset with a pending miss: everything must stay quiet
    rst             = 1'b1;
    bus.miss_cache  = 1'b1;
    bus.ram_address = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_word_ready", 32'(bus.word_ready), 32'd0);
    checkOutput("rst_line_done",  32'(bus.line_done),  32'd0);
    checkOutput("rst_busy",       32'(bus.busy),       32'd0);
    checkOutput("rst_rd_en",      32'(bus.ram_rd_en),  32'd0);
    checkOutput("rst_rd_addr",    32'(bus.ram_rd_addr), 32'd0);
    checkOutput("rst_mem_word",   bus.mem_word,        32'd0);
    checkOutput("rst_word_idx",   32'(bus.word_idx),   32'd0);

    // Per-cycle vector table
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_rd_en", i), 32'(bus.ram_rd_en), 32'(vecs[i].en));
      if (vecs[i].en)
        checkOutput($sformatf("vec%0d_rd_addr", i), 32'(bus.ram_rd_addr), 32'(vecs[i].rd_addr));
      checkOutput($sformatf("vec%0d_word_ready", i), 32'(bus.word_ready), 32'(vecs[i].wr));
      checkOutput($sformatf("vec%0d_mem_word", i), bus.mem_word, vecs[i].word);
      if (vecs[i].wr)
        checkOutput($sformatf("vec%0d_word_idx", i), 32'(bus.word_idx), 32'(vecs[i].idx));
      checkOutput($sformatf("vec%0d_line_done", i), 32'(bus.line_done), 32'(vecs[i].ld));
      checkOutput($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
    end

    // Stale miss held 5 cycles in DONE, then a fresh miss at 0x200
    checkBurst(32'h100, 5);
    checkBurst(32'h200, 0);

    // Reset pulsed at T+5 of a burst: late returns must be dropped
    @(negedge clk);
    bus.miss_cache  = 1'b1;
    bus.ram_address = 32'h100;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.miss_cache = 1'b0;
      rst = (c == 5);
    end
    #1;
    checkOutput("rstmid_pre_word_ready", 32'(bus.word_ready), 32'd1);
    for (int c = 6; c <= 13; c++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rstmid_word_ready", 32'(bus.word_ready), 32'd0);
      checkOutput("rstmid_line_done",  32'(bus.line_done),  32'd0);
      checkOutput("rstmid_busy",       32'(bus.busy),       32'd0);
      checkOutput("rstmid_rd_en",      32'(bus.ram_rd_en),  32'd0);
    end
    checkBurst(32'h100, 0);
    checkBurst(32'h108, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
